// File: rtl/cls_text_sequencer_pkg.sv
// Shared types and constants for the PMOD CLS text sequencer.
// Holds the state encoding, the blank-line constant and the refresh-period helper.
package cls_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_CLR_WAIT_RDY = 4'd1,
        S_CLR_ISSUE    = 4'd2,
        S_CLR_WAIT_LOW = 4'd3,
        S_L1_WAIT_RDY  = 4'd4,
        S_L1_ISSUE     = 4'd5,
        S_L1_WAIT_LOW  = 4'd6,
        S_L2_WAIT_RDY  = 4'd7,
        S_L2_ISSUE     = 4'd8,
        S_L2_WAIT_LOW  = 4'd9,
        S_L2_WAIT_DONE = 4'd10
    } t_cls_seq_state;

    localparam logic [127:0] c_ascii_blank_line   = {16{8'h20}};
    localparam int           c_fast_refresh_ticks = 250;

    function automatic int f_refresh_ticks(input int fast, input int fclk_ce, input int refresh_ms);
        if (fast != 0) return c_fast_refresh_ticks;
        return fclk_ce / 1000 * refresh_ms;
    endfunction

endpackage

// File: rtl/cls_text_sequencer_if.sv
// Command/data bundle between the text sequencer and its host/driver side.
// slave is the sequencer's view; master is the view of whoever drives it.
interface cls_text_sequencer_if;

    logic         i_update_req;
    logic [127:0] i_text_line1;
    logic [127:0] i_text_line2;
    logic         i_command_ready;
    logic         o_cmd_wr_clear_display;
    logic         o_cmd_wr_text_line1;
    logic         o_cmd_wr_text_line2;
    logic [127:0] o_dat_ascii_line1;
    logic [127:0] o_dat_ascii_line2;
    logic         o_busy;
    logic         o_timeout_err;

    modport slave (
        input  i_update_req, i_text_line1, i_text_line2, i_command_ready,
        output o_cmd_wr_clear_display, o_cmd_wr_text_line1, o_cmd_wr_text_line2,
        output o_dat_ascii_line1, o_dat_ascii_line2, o_busy, o_timeout_err
    );

    modport master (
        output i_update_req, i_text_line1, i_text_line2, i_command_ready,
        input  o_cmd_wr_clear_display, o_cmd_wr_text_line1, o_cmd_wr_text_line2,
        input  o_dat_ascii_line1, o_dat_ascii_line2, o_busy, o_timeout_err
    );

endinterface

// File: rtl/cls_text_sequencer_refresh_timer.sv
// Free-running ce-qualified refresh counter; pulses refresh_tick for one ce tick per period.
// A restart forces the count back to zero so the period is measured from sequence start.
module cls_refresh_timer #(
    parameter int period_ticks = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic restart,
    output logic refresh_tick
);

    localparam int                 c_width = (period_ticks > 1) ? $clog2(period_ticks) : 1;
    localparam logic [c_width-1:0] c_last  = c_width'(period_ticks - 1);

    logic [c_width-1:0] count;

    assign refresh_tick = ce && (count == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ce) begin
            if (restart || (count == c_last)) count <= '0;
            else                              count <= count + c_width'(1);
        end
    end

endmodule

// File: rtl/cls_text_sequencer.sv
// Sequences clear / line 1 / line 2 commands into the PMOD CLS driver using its ready handshake,
// on request, after reset, and periodically so the display recovers from power glitches.
//
// state          | meaning
// IDLE           | waiting for pending, update request or refresh tick
// X_WAIT_RDY     | waiting for driver ready before issuing command X (CLR, L1, L2)
// X_ISSUE        | command X pulse is high for this ce tick
// X_WAIT_LOW     | waiting for ready to drop (acceptance), bounded by the accept timeout
// L2_WAIT_DONE   | waiting for ready after line 2, then back to IDLE
module cls_text_sequencer
    import cls_seq_pkg::*;
#(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK_ce              = 2500000,
    parameter int parm_refresh_ms      = 1000,
    parameter int parm_accept_timeout  = 16
) (
    input  logic                 i_clk_20mhz,
    input  logic                 i_rst_20mhz,
    input  logic                 i_ce_2_5mhz,
    cls_text_sequencer_if.slave  bus
);

    localparam int c_refresh_ticks = f_refresh_ticks(parm_fast_simulation, FCLK_ce, parm_refresh_ms);
    localparam int c_to_width      = $clog2(parm_accept_timeout + 1);
    localparam logic [c_to_width-1:0] c_to_load = c_to_width'(parm_accept_timeout - 1);

    localparam logic [3:0] ST_IDLE         = S_IDLE;
    localparam logic [3:0] ST_CLR_WAIT_RDY = S_CLR_WAIT_RDY;
    localparam logic [3:0] ST_CLR_ISSUE    = S_CLR_ISSUE;
    localparam logic [3:0] ST_CLR_WAIT_LOW = S_CLR_WAIT_LOW;
    localparam logic [3:0] ST_L1_WAIT_RDY  = S_L1_WAIT_RDY;
    localparam logic [3:0] ST_L1_ISSUE     = S_L1_ISSUE;
    localparam logic [3:0] ST_L1_WAIT_LOW  = S_L1_WAIT_LOW;
    localparam logic [3:0] ST_L2_WAIT_RDY  = S_L2_WAIT_RDY;
    localparam logic [3:0] ST_L2_ISSUE     = S_L2_ISSUE;
    localparam logic [3:0] ST_L2_WAIT_LOW  = S_L2_WAIT_LOW;
    localparam logic [3:0] ST_L2_WAIT_DONE = S_L2_WAIT_DONE;

    logic [3:0]            state;
    logic                  pending;
    logic [127:0]          shadow_line1;
    logic [127:0]          shadow_line2;
    logic [127:0]          dat_line1;
    logic [127:0]          dat_line2;
    logic [c_to_width-1:0] to_count;
    logic                  cmd_clr;
    logic                  cmd_l1;
    logic                  cmd_l2;
    logic                  busy;
    logic                  timeout_err;
    logic                  refresh_tick;
    logic                  start_seq;
    logic                  ready;
    logic                  req;

    assign ready     = bus.i_command_ready;
    assign req       = bus.i_update_req;
    assign start_seq = i_ce_2_5mhz && (state == ST_IDLE) && (pending || req || refresh_tick);

    cls_refresh_timer #(
        .period_ticks (c_refresh_ticks)
    ) u_refresh_timer (
        .clk          (i_clk_20mhz),
        .rst          (i_rst_20mhz),
        .ce           (i_ce_2_5mhz),
        .restart      (start_seq),
        .refresh_tick (refresh_tick)
    );

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state        <= ST_IDLE;
            pending      <= 1'b1;
            shadow_line1 <= c_ascii_blank_line;
            shadow_line2 <= c_ascii_blank_line;
            dat_line1    <= c_ascii_blank_line;
            dat_line2    <= c_ascii_blank_line;
            to_count     <= c_to_load;
            cmd_clr      <= 1'b0;
            cmd_l1       <= 1'b0;
            cmd_l2       <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (i_ce_2_5mhz) begin
            // Shadow always tracks the newest text; outputs only pick it up at sequence start.
            if (state != ST_IDLE) begin
                if (req) begin
                    shadow_line1 <= bus.i_text_line1;
                    shadow_line2 <= bus.i_text_line2;
                end
                if (req || refresh_tick) pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pending || req || refresh_tick) begin
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_CLR_WAIT_RDY;
                        if (req) begin
                            shadow_line1 <= bus.i_text_line1;
                            shadow_line2 <= bus.i_text_line2;
                            dat_line1    <= bus.i_text_line1;
                            dat_line2    <= bus.i_text_line2;
                        end else begin
                            dat_line1 <= shadow_line1;
                            dat_line2 <= shadow_line2;
                        end
                    end
                end
                ST_CLR_WAIT_RDY: begin
                    if (ready) begin
                        cmd_clr <= 1'b1;
                        state   <= ST_CLR_ISSUE;
                    end
                end
                ST_CLR_ISSUE: begin
                    cmd_clr  <= 1'b0;
                    to_count <= c_to_load;
                    state    <= ST_CLR_WAIT_LOW;
                end
                ST_CLR_WAIT_LOW: begin
                    if (!ready) begin
                        state <= ST_L1_WAIT_RDY;
                    end else if (to_count == '0) begin
                        timeout_err <= 1'b1;
                        state       <= ST_L1_WAIT_RDY;
                    end else begin
                        to_count <= to_count - c_to_width'(1);
                    end
                end
                ST_L1_WAIT_RDY: begin
                    if (ready) begin
                        cmd_l1 <= 1'b1;
                        state  <= ST_L1_ISSUE;
                    end
                end
                ST_L1_ISSUE: begin
                    cmd_l1   <= 1'b0;
                    to_count <= c_to_load;
                    state    <= ST_L1_WAIT_LOW;
                end
                ST_L1_WAIT_LOW: begin
                    if (!ready) begin
                        state <= ST_L2_WAIT_RDY;
                    end else if (to_count == '0) begin
                        timeout_err <= 1'b1;
                        state       <= ST_L2_WAIT_RDY;
                    end else begin
                        to_count <= to_count - c_to_width'(1);
                    end
                end
                ST_L2_WAIT_RDY: begin
                    if (ready) begin
                        cmd_l2 <= 1'b1;
                        state  <= ST_L2_ISSUE;
                    end
                end
                ST_L2_ISSUE: begin
                    cmd_l2   <= 1'b0;
                    to_count <= c_to_load;
                    state    <= ST_L2_WAIT_LOW;
                end
                ST_L2_WAIT_LOW: begin
                    if (!ready) begin
                        state <= ST_L2_WAIT_DONE;
                    end else if (to_count == '0) begin
                        timeout_err <= 1'b1;
                        state       <= ST_L2_WAIT_DONE;
                    end else begin
                        to_count <= to_count - c_to_width'(1);
                    end
                end
                ST_L2_WAIT_DONE: begin
                    if (ready) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_clr <= 1'b0;
                    cmd_l1  <= 1'b0;
                    cmd_l2  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_cmd_wr_clear_display = cmd_clr;
    assign bus.o_cmd_wr_text_line1    = cmd_l1;
    assign bus.o_cmd_wr_text_line2    = cmd_l2;
    assign bus.o_dat_ascii_line1      = dat_line1;
    assign bus.o_dat_ascii_line2      = dat_line2;
    assign bus.o_busy                 = busy;
    assign bus.o_timeout_err          = timeout_err;

endmodule

// File: doc/cls_text_sequencer.md
# cls_text_sequencer

Upstream command source for `pmod_cls_custom_driver`. It latches two 16-character ASCII lines on request, then issues the three driver commands in order: clear display, write line 1, write line 2. It uses the driver's `command_ready` handshake. It also re-sends the same sequence on a periodic refresh timer, so the PMOD CLS recovers after a power glitch. It runs in the 20 MHz domain and advances only on the 2.5 MHz clock enable, the same as the driver.

## Interface
- `parm_fast_simulation`, 0, 1 shortens the refresh period to 250 ce ticks.
- `FCLK_ce`, 2500000, clock-enable rate in Hz.
- `parm_refresh_ms`, 1000, refresh period in ms (ce ticks = `FCLK_ce/1000*parm_refresh_ms`).
- `parm_accept_timeout`, 16, ce ticks to wait for `command_ready` to drop after an issue.
- `i_clk_20mhz`  in  1  clock (one clock).
- `i_rst_20mhz`  in  1  reset, synchronous and active-high.
- `i_ce_2_5mhz`  in  1  clock enable; all FSM and timer updates are qualified by it.
- `i_update_req`  in  1  one-cycle request to display new text; sampled on ce.
- `i_text_line1`  in  128  line 1 text, 16 ASCII chars, MSB byte is leftmost.
- `i_text_line2`  in  128  line 2 text, same format.
- `i_command_ready`  in  1  driver's `o_command_ready`.
- `o_cmd_wr_clear_display`  out  1  one-ce-tick command pulse.
- `o_cmd_wr_text_line1`  out  1  one-ce-tick command pulse.
- `o_cmd_wr_text_line2`  out  1  one-ce-tick command pulse.
- `o_dat_ascii_line1`  out  128  latched line 1; stable during a sequence.
- `o_dat_ascii_line2`  out  128  latched line 2; stable during a sequence.
- `o_busy`  out  1  high from sequence start until line 2 completes.
- `o_timeout_err`  out  1  sticky; set when an accept wait times out; cleared by reset.

## Operation
- Reset values:
  - all commands, `o_busy` and `o_timeout_err` are 0;
  - both data outputs are sixteen 0x20 spaces;
  - `pending` = 1, so the first sequence runs after reset;
  - refresh counter = 0.
- Trigger conditions (evaluated in S_IDLE on a ce tick):
  - `pending`, or
  - `i_update_req`, or
  - `refresh_tick`.
- On a trigger: latch both text inputs if `i_update_req` is high (otherwise keep the current buffers), clear `pending`, and go to S_CLR_WAIT_RDY.
- Per-command sub-sequence, X ∈ {CLR, L1, L2}:
  - S_X_WAIT_RDY: wait for `i_command_ready`=1, then go to S_X_ISSUE.
  - S_X_ISSUE: drive the command high for exactly one ce tick, then go to S_X_WAIT_LOW.
  - S_X_WAIT_LOW: wait for `i_command_ready`=0, which counts as acceptance. If `parm_accept_timeout` ce ticks pass without it, set `o_timeout_err` and advance anyway.
- Command order: CLR, then L1, then L2. After L2's WAIT_LOW: go to S_L2_WAIT_DONE, wait for ready=1, then return to S_IDLE.
- Requests while busy: an `i_update_req` while `o_busy` latches the new text into a shadow buffer and sets `pending`. The shadow copies to the output buffers only on entry to S_CLR_WAIT_RDY, so the data never changes mid-sequence. A later request overwrites the shadow (last one wins).
- Refresh timer:
  - free-running; pulses `refresh_tick` for one ce tick at the period, then wraps to 0;
  - restarts at 0 when any sequence starts;
  - a tick during busy sets `pending`.
- Simultaneous request and tick in S_IDLE start one sequence, using the new text.

## Timing
- Latency:
  - idle request to the `o_cmd_wr_clear_display` pulse is 2 ce ticks when ready is already high (trigger tick, then WAIT_RDY → ISSUE);
  - each subsequent command follows its predecessor's re-ready by 2 ce ticks.
- Each command pulse is high for 8 `i_clk_20mhz` cycles (one ce period). It is registered and never coincident with another command.
- `o_busy` rises on the trigger tick and falls on entry to S_IDLE.
- Reset mid-sequence: commands drop at the next clock edge, and the FSM returns to S_IDLE with `pending`=1.
- The refresh counter width is `$clog2` of the period. No arithmetic wrap other than the period wrap.

## Structure
- Package `cls_seq_pkg`:
  - `t_cls_seq_state` enum (S_IDLE, S_CLR_WAIT_RDY, S_CLR_ISSUE, S_CLR_WAIT_LOW, S_L1_*, S_L2_*, S_L2_WAIT_DONE);
  - `c_ascii_blank_line` (128'h20…20);
  - `c_fast_refresh_ticks` = 250.
- One sub-module, `cls_refresh_timer`: ce-qualified counter with restart input and `refresh_tick` output.
- The FSM, text buffers and timeout counter stay in the top.

## Test plan
- After reset, hold ready=1 → CLR, L1, L2 pulses are each 8 clocks wide, carry space data, and end with `o_busy`=0.
- In idle, request with line1 = "ACCEL X:+0012 mg" and line2 = "ACCEL Y:-0004 mg" → the data outputs show those strings during the CLR pulse; CLR precedes L1 precedes L2.
- Request at the start of L1's WAIT_LOW with line1 = "NEW" → the current sequence completes with the old text, then a second sequence starts with "NEW". Two requests during busy → only the last text is shown.
- Hold ready=1 permanently after an issue, so it never drops → after 16 ce ticks `o_timeout_err`=1 and the sequence still advances to L1.
- With `parm_fast_simulation`=1 and no requests → a refresh sequence starts every 250 ce ticks after the previous one starts; it uses the unchanged text.
- Assert reset during the L1 pulse → all commands are 0 on the next edge; after release, a full sequence is re-sent with blank text.
